// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter in front of one UART transmitter; define UART_ARB_BURST_EN for multi-byte bursts
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   input  logic                       tx_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       arb_busy
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
   state_t        state;
   logic [IW-1:0] rr_ptr, rr_next, next_id, idx, winner;
   logic [7:0]    win_byte;
   if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_params
   end
   // Scan from the far end back toward rr_ptr so the nearest valid index wins.
   always_comb begin
      winner   = rr_ptr;
      idx      = rr_ptr;
      win_byte = 8'h00;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[idx]) winner = idx;
      end
      for (int i = 0; i < NUM_REQ; i++) if (winner == IW'(i)) win_byte = req_data[8*i +: 8];
   end
   assign next_id = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
`ifdef UART_ARB_BURST_EN
   logic [4:0] burst_cnt;
   logic       burst_stay;
   assign burst_stay = req_valid[grant_id] && (burst_cnt < 5'(BURST_LEN - 1));
   assign rr_next    = burst_stay ? grant_id : next_id;
   always_ff @(posedge clk) begin
      if (!reset_n) burst_cnt <= '0;
      else if (state == WAIT_DONE && !tx_busy) burst_cnt <= burst_stay ? burst_cnt + 1'b1 : '0;
   end
`else
   assign rr_next = next_id;
`endif
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         req_ack  <= '0;
         arb_busy <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         req_ack  <= '0;
         case (state)
            IDLE: if (!tx_busy && |req_valid) begin
               state    <= START;
               grant_id <= winner;
               tx_data  <= win_byte;
               tx_start <= 1'b1;
               req_ack  <= NUM_REQ'(1) << winner;
               arb_busy <= 1'b1;
            end
            START:     state <= WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
            WAIT_DONE: if (!tx_busy) begin
               state    <= IDLE;
               arb_busy <= 1'b0;
               rr_ptr   <= rr_next;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
